cpu_seq_ctrl: RTL and testbench
===============================

# cpu_seq_ctrl

Multi-cycle sequencing controller for the 16-bit `cpu` datapath (PC, instruction register, 16×16 register file `rf`, ALU, unified memory port). It walks each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select and holds on a ready/request memory handshake. It also counts retired instructions and stops cleanly on a HALT opcode or a memory timeout.

## Interface
- `MEM_TIMEOUT`, 15: max cycles `mem_req` may wait for `mem_ready` before bus error (1..255)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: leave IDLE and begin fetching; ignored in any other state
- `opcode` in 4: IR[15:12] from the datapath, valid from DECODE onward
- `zero` in 1: ALU zero flag, sampled in EXEC for BEQ
- `mem_ready` in 1: memory completes the current request this cycle
- `ir_we` out 1: load IR from memory read data
- `pc_we` out 1: update PC
- `pc_src` out 2: 0 = PC+1, 1 = PC+sext(imm) (branch), 2 = jump target
- `alu_src` out 1: 0 = rs2, 1 = immediate
- `alu_op` out 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT
- `rf_we` out 1: register-file write enable
- `wb_sel` out 1: 0 = ALU result, 1 = memory read data
- `mem_req` out 1: memory request pending
- `mem_we` out 1: write request; valid only with `mem_req`
- `halted` out 1: controller is in HALT
- `bus_err` out 1: sticky memory-timeout flag
- `illegal` out 1: one-cycle pulse on an undefined opcode
- `state` out 3: current state encoding, for debug
- `retired` out 16: retired-instruction count, wraps 0xFFFF→0

## Operation
- **States:**
  - IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6.
  - Encoding 7 is unreachable; if entered it goes to HALT.
- **Opcodes:**
  - 0–5: R-type ALU ops.
  - 6: ADDI.
  - 8: LW (addr = rs1 + imm).
  - 9: SW.
  - A: BEQ.
  - B: JMP.
  - F: HALT.
  - All others are illegal.
- **IDLE:** all strobes 0. Goes to FETCH when `start` = 1.
- **FETCH:**
  - `mem_req` = 1, `mem_we` = 0.
  - On `mem_ready`: `ir_we` = 1, `pc_we` = 1, `pc_src` = 0, then go to DECODE.
- **DECODE:**
  - Latch `opcode` into internal `op_q`.
  - Opcode F goes to HALT; the HALT instruction itself is not counted as retired.
  - An illegal opcode pulses `illegal` and goes to FETCH; it is retired as a NOP.
  - Every other opcode goes to EXEC.
- **EXEC:**
  - `alu_op` and `alu_src` are driven from `op_q`:
    - R-type: op 0–5, `alu_src` = 0.
    - ADDI, LW, SW: ADD with `alu_src` = 1.
    - BEQ: SUB with `alu_src` = 0.
  - R-type and ADDI go to WB.
  - LW and SW go to MEM.
  - BEQ: `pc_we` = `zero`, `pc_src` = 1, then retire and go to FETCH.
  - JMP: `pc_we` = 1, `pc_src` = 2, then retire and go to FETCH.
- **MEM:**
  - `mem_req` = 1; `mem_we` = 1 for SW.
  - On `mem_ready`: LW goes to WB; SW retires and goes to FETCH.
- **WB:**
  - `rf_we` = 1; `wb_sel` = 1 for LW, 0 otherwise.
  - Retires and goes to FETCH.
- **HALT:**
  - `halted` = 1, all other strobes 0.
  - Leaves only on `rst`; `start` is ignored.
- **Timeout:**
  - A wait counter clears on entering FETCH or MEM and counts each cycle that `mem_req` = 1 and `mem_ready` = 0.
  - When it reaches `MEM_TIMEOUT`: set `bus_err`, go to HALT, and retire nothing.
  - If `mem_ready` arrives in the same cycle the count reaches `MEM_TIMEOUT`, the completion wins.
- **Strobe decode:** all strobes decode from the registered `state` and `op_q`. The only combinational inputs to them are `mem_ready` (FETCH) and `zero` (EXEC). No strobe is asserted outside its listed state.

## Timing
- **Reset:**
  - `rst` has priority over everything, mid-instruction included.
  - On the next edge: state = IDLE, `retired` = 0, `bus_err` = 0, `op_q` = 0, wait counter = 0.
  - All outputs read 0 except `state` = 0.
  - A memory request in flight is dropped: `mem_req` is low the cycle after reset.
- **Latency with zero-wait memory** (`mem_ready` high in the first request cycle):
  - R-type / ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ / JMP: 3 cycles.
  - Each memory wait cycle adds 1.
- **IDLE to first fetch:** `start` sampled high puts FETCH in the next cycle.
- **Retire count:** `retired` increments on the edge that leaves the instruction's final state, and is visible the following cycle.
- **Memory handshake:**
  - `mem_req` stays high and stable until the cycle in which `mem_ready` = 1.
  - `mem_we` does not change while a request is pending.
  - `mem_ready` without `mem_req` is ignored.

## Test plan
- **Reset:** `rst` for 2 cycles, then `start` → state walks IDLE → FETCH; all outputs 0 during reset; `retired` = 0.
- **ADD:** opcode 0 with zero-wait memory → `ir_we`/`pc_we` in cycle 1; `alu_op` = 0 in cycle 3; `rf_we` = 1, `wb_sel` = 0 in cycle 4; `retired` = 1.
- **LW with wait states:** `mem_ready` delayed 3 cycles in MEM → `mem_req` held 4 cycles with `mem_we` = 0; `rf_we` with `wb_sel` = 1 one cycle later; 8 cycles total.
- **BEQ:**
  - `zero` = 1 → `pc_we` = 1 with `pc_src` = 1.
  - `zero` = 0 → `pc_we` = 0.
  - Both finish in 3 cycles; `retired` increments each time.
- **Timeout:** `mem_ready` held low in FETCH with `MEM_TIMEOUT` = 15 → after 15 waiting cycles `bus_err` = 1, `halted` = 1, `retired` unchanged; `start` ignored.
- **HALT / illegal / reset mid-instruction:**
  - Opcode F → HALT after DECODE.
  - Opcode 7 → one `illegal` pulse, then FETCH.
  - `rst` asserted during MEM → IDLE with `mem_req` = 0 on the next cycle.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_ctrl
//  Description : Multi-cycle fetch/decode/execute/memory/write-back sequencer
//                for the 16-bit cpu datapath, with memory-timeout halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_decode = 3'd2;
  localparam logic [2:0] c_st_exec   = 3'd3;
  localparam logic [2:0] c_st_mem    = 3'd4;
  localparam logic [2:0] c_st_wb     = 3'd5;
  localparam logic [2:0] c_st_halt   = 3'd6;

  localparam logic [3:0] c_op_addi = 4'h6;
  localparam logic [3:0] c_op_lw   = 4'h8;
  localparam logic [3:0] c_op_sw   = 4'h9;
  localparam logic [3:0] c_op_beq  = 4'hA;
  localparam logic [3:0] c_op_jmp  = 4'hB;
  localparam logic [3:0] c_op_halt = 4'hF;

  localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

  logic [2:0]  r_state;
  logic [3:0]  r_op;
  logic [7:0]  r_wait;
  logic [15:0] r_retired;
  logic        r_bus_err;

  logic [2:0]  w_next;
  logic        w_timeout;
  logic        w_retire;
  logic        w_legal;

  assign w_legal = (opcode <= 4'd6) || ((opcode >= c_op_lw) && (opcode <= c_op_jmp)) ||
                   (opcode == c_op_halt);

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_retire  = 1'b0;
    case (r_state)
      c_st_idle:   if (start) w_next = c_st_fetch;
      c_st_fetch: begin
        // a completion arriving in the same cycle as the limit takes priority
        if (mem_ready) begin
          w_next = c_st_decode;
        end else if (r_wait == c_timeout) begin
          w_next    = c_st_halt;
          w_timeout = 1'b1;
        end
      end
      c_st_decode: begin
        if (opcode == c_op_halt) begin
          w_next = c_st_halt;
        end else if (!w_legal) begin
          w_next   = c_st_fetch;
          w_retire = 1'b1;
        end else begin
          w_next = c_st_exec;
        end
      end
      c_st_exec: begin
        if ((r_op <= 4'd5) || (r_op == c_op_addi)) begin
          w_next = c_st_wb;
        end else if ((r_op == c_op_lw) || (r_op == c_op_sw)) begin
          w_next = c_st_mem;
        end else begin
          w_next   = c_st_fetch;
          w_retire = (r_op == c_op_beq) || (r_op == c_op_jmp);
        end
      end
      c_st_mem: begin
        if (mem_ready) begin
          w_next   = (r_op == c_op_lw) ? c_st_wb : c_st_fetch;
          w_retire = (r_op == c_op_sw);
        end else if (r_wait == c_timeout) begin
          w_next    = c_st_halt;
          w_timeout = 1'b1;
        end
      end
      c_st_wb: begin
        w_next   = c_st_fetch;
        w_retire = 1'b1;
      end
      c_st_halt:   w_next = c_st_halt;
      default:     w_next = c_st_halt;
    endcase
  end

  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_src  = 2'd0;
    alu_src = 1'b0;
    alu_op  = 3'd0;
    rf_we   = 1'b0;
    wb_sel  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (r_state)
      c_st_fetch: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      c_st_decode: illegal = !w_legal;
      c_st_exec: begin
        if (r_op <= 4'd5) begin
          alu_op = r_op[2:0];
        end else if (r_op == c_op_beq) begin
          alu_op = 3'd1;
          pc_we  = zero;
          pc_src = 2'd1;
        end else if (r_op == c_op_jmp) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end else begin
          alu_src = 1'b1;
        end
      end
      c_st_mem: begin
        mem_req = 1'b1;
        mem_we  = (r_op == c_op_sw);
      end
      c_st_wb: begin
        rf_we  = 1'b1;
        wb_sel = (r_op == c_op_lw);
      end
      c_st_halt: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_op      <= 4'd0;
      r_wait    <= 8'd0;
      r_retired <= 16'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == c_st_decode) r_op <= opcode;
      // any state change restarts the wait count for the next request
      if (w_next != r_state) begin
        r_wait <= 8'd0;
      end else if (mem_req && !mem_ready) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_retire) r_retired <= r_retired + 16'd1;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  assign state   = r_state;
  assign retired = r_retired;
  assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_seq_ctrl
//  Description : Self-checking bench for cpu_seq_ctrl (vector table, corner
//                sequences and random instructions against a reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_we, pc_we, alu_src, rf_we, wb_sel, mem_req, mem_we;
  logic        halted, bus_err, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op, state;
  logic [15:0] retired;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_seq_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src(alu_src), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .bus_err(bus_err),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // inputs: op z fw mw ; expected per-instruction totals and observed values
  typedef struct {
    int op, z, fw, mw;
    int cycles, ret, ir, pc, rf, req, we, ill, halt, berr, exec, alu, src, pcs, wb;
  } rec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Instruction-level reference: totals derived from the opcode class and wait counts.
  function automatic rec_t model(input int op, input int z, input int fw, input int mw);
    rec_t r = '{default: 0};
    int mc;
    r.op = op; r.z = z; r.fw = fw; r.mw = mw;
    if (fw > T) begin
      r.cycles = T + 1; r.req = T + 1; r.halt = 1; r.berr = 1;
      return r;
    end
    r.cycles = fw + 2; r.req = fw + 1; r.ir = 1; r.pc = 1;
    if (op == 15) begin
      r.halt = 1;
      return r;
    end
    if (!(op <= 6 || (op >= 8 && op <= 11))) begin
      r.ill = 1; r.ret = 1;
      return r;
    end
    r.exec = 1; r.cycles++;
    if (op <= 5) r.alu = op;
    else if (op == 10) r.alu = 1;
    else if (op != 11) r.src = 1;
    if (op <= 6) begin
      r.cycles++; r.rf = 1; r.ret = 1;
    end else if (op == 8 || op == 9) begin
      mc = (mw > T) ? T + 1 : mw + 1;
      r.cycles += mc; r.req += mc;
      if (op == 9) r.we = mc;
      if (mw > T) begin
        r.halt = 1; r.berr = 1;
      end else begin
        r.ret = 1;
        if (op == 8) begin r.cycles++; r.rf = 1; r.wb = 1; end
      end
    end else if (op == 10) begin
      r.ret = 1;
      if (z != 0) begin r.pc++; r.pcs = 1; end
    end else begin
      r.ret = 1; r.pc++; r.pcs = 2;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("reset outputs", int'({ir_we, pc_we, pc_src, alu_src, alu_op, rf_we, wb_sel,
          mem_req, mem_we, halted, bus_err, illegal, state}), 0);
    check("reset retired", int'(retired), 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    check("start to FETCH", int'(state), 1);
    start = 1'b0;
  endtask

  // Starts just after a negedge in the instruction's first FETCH cycle.
  task automatic run_instr(input rec_t e, input string tag);
    int cyc = 0, rcnt = 0, n_ir = 0, n_pc = 0, n_rf = 0, n_req = 0, n_we = 0, n_ill = 0;
    int alu_s = 0, src_s = 0, pcs_s = 0, wb_s = 0, fbad = 0;
    bit other = 0, ex_seen = 0, done = 0;
    logic [2:0]  prev = 3'd7;
    logic [15:0] ret0, dret;
    ret0 = retired;
    opcode = 4'(e.op);
    zero = e.z[0];
    while (!done) begin
      if (state != prev) rcnt = 0;
      prev = state;
      start = 1'($urandom_range(0, 1));
      if (mem_req) begin
        mem_ready = (rcnt == ((state == 3'd1) ? e.fw : e.mw));
        rcnt++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      cyc++;
      if (state != 3'd1) other = 1;
      if (ir_we) n_ir++;
      if (pc_we) n_pc++;
      if (rf_we) begin n_rf++; wb_s = int'(wb_sel); end
      if (mem_req) n_req++;
      if (mem_we) n_we++;
      if (illegal) n_ill++;
      if (state == 3'd1 && pc_we && pc_src != 2'd0) fbad++;
      if (state == 3'd3) begin
        ex_seen = 1; alu_s = int'(alu_op); src_s = int'(alu_src);
        if (pc_we) pcs_s = int'(pc_src);
      end
      @(negedge clk);
      if (state == 3'd6 || (state == 3'd1 && other)) done = 1;
      else if (cyc >= 300) begin
        check({tag, " cycle bound"}, cyc, e.cycles);
        done = 1;
      end
    end
    start = 1'b0;
    mem_ready = 1'b0;
    dret = retired - ret0;
    check({tag, " cycles"}, cyc, e.cycles);
    check({tag, " retired"}, int'(dret), e.ret);
    check({tag, " ir_we"}, n_ir, e.ir);
    check({tag, " pc_we"}, n_pc, e.pc);
    check({tag, " rf_we"}, n_rf, e.rf);
    check({tag, " mem_req"}, n_req, e.req);
    check({tag, " mem_we"}, n_we, e.we);
    check({tag, " illegal"}, n_ill, e.ill);
    check({tag, " halted"}, int'(halted), e.halt);
    check({tag, " bus_err"}, int'(bus_err), e.berr);
    check({tag, " exec"}, int'(ex_seen), e.exec);
    check({tag, " fetch pc_src"}, fbad, 0);
    if (e.exec != 0 && e.op != 11) begin
      check({tag, " alu_op"}, alu_s, e.alu);
      check({tag, " alu_src"}, src_s, e.src);
    end
    if (e.pcs != 0) check({tag, " pc_src"}, pcs_s, e.pcs);
    if (e.rf != 0) check({tag, " wb_sel"}, wb_s, e.wb);
  endtask

  task automatic halt_followup(input string tag);
    logic [15:0] r0;
    r0 = retired;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, " stays HALT"}, int'(state), 6);
    check({tag, " halted held"}, int'(halted), 1);
    check({tag, " retired frozen"}, int'(retired), int'(r0));
    start = 1'b0;
    do_reset();
  endtask

  rec_t tbl[18];

  initial begin
    rec_t e;
    int op, fw, mw;
    //           op  z  fw mw  cyc ret ir pc rf req we ill hlt berr ex alu src pcs wb
    tbl[0]  = '{ 0, 0, 0, 0,   4, 1, 1, 1, 1,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{ 1, 1, 2, 0,   6, 1, 1, 1, 1,  3, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{ 5, 0, 0, 0,   4, 1, 1, 1, 1,  1, 0, 0, 0, 0, 1, 5, 0, 0, 0};
    tbl[3]  = '{ 6, 0, 1, 0,   5, 1, 1, 1, 1,  2, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[4]  = '{ 8, 0, 0, 3,   8, 1, 1, 1, 1,  5, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    tbl[5]  = '{ 9, 0, 0, 0,   4, 1, 1, 1, 0,  2, 1, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[6]  = '{ 9, 0, 1, 2,   7, 1, 1, 1, 0,  5, 3, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[7]  = '{10, 1, 0, 0,   3, 1, 1, 2, 0,  1, 0, 0, 0, 0, 1, 1, 0, 1, 0};
    tbl[8]  = '{10, 0, 0, 0,   3, 1, 1, 1, 0,  1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{11, 0, 0, 0,   3, 1, 1, 2, 0,  1, 0, 0, 0, 0, 1, 0, 0, 2, 0};
    tbl[10] = '{ 7, 0, 0, 0,   2, 1, 1, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{12, 0, 1, 0,   3, 1, 1, 1, 0,  2, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{ 0, 0,15, 0,  19, 1, 1, 1, 1, 16, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[13] = '{ 3, 1, 0, 0,   4, 1, 1, 1, 1,  1, 0, 0, 0, 0, 1, 3, 0, 0, 0};
    tbl[14] = '{15, 0, 0, 0,   2, 0, 1, 1, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{ 0, 0,16, 0,  16, 0, 0, 0, 0, 16, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[16] = '{ 8, 0, 0,16,  19, 0, 1, 1, 0, 17, 0, 0, 1, 1, 1, 0, 1, 0, 0};
    tbl[17] = '{ 9, 0, 0,16,  19, 0, 1, 1, 0, 17,16, 0, 1, 1, 1, 0, 1, 0, 0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      run_instr(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].halt != 0) halt_followup($sformatf("vec%0d", i));
    end

    // reset while a data-memory request is outstanding
    opcode = 4'h8;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("midmem in MEM", int'(state), 4);
    check("midmem req high", int'(mem_req), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midmem req dropped", int'(mem_req), 0);
    check("midmem state IDLE", int'(state), 0);
    check("midmem retired clear", int'(retired), 0);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    check("midmem restart FETCH", int'(state), 1);
    start = 1'b0;

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 15);
      if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
      fw = ($urandom_range(0, 24) == 0) ? T + 1 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 19) == 0) ? T + 1 + $urandom_range(0, 1) : $urandom_range(0, 4);
      e = model(op, $urandom_range(0, 1), fw, mw);
      run_instr(e, $sformatf("rnd%0d op%0d", i, op));
      if (e.halt != 0) halt_followup($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
